mult_result_stage: RTL

// - Downstream consumer of the Booth multiplier pipeline register.
// - Detects completion of a multiply on done_in and extracts the 64-bit product

---
 rtl/mult_result_if.sv | 34 +++
 rtl/mult_result_stage.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mult_result_if.sv
// Result-side bundle of the multiplier result stage: the completion input from
// the pipeline register and the buffered valid/ready product output.
// master: the result stage itself.
// slave:  the producer of done_in/phase_result_in and the consumer of products.
interface mult_result_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             done_in;
    logic [64:0]      phase_result_in;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_product;
    logic [CNT_W-1:0] res_count;

    modport master (
        input  done_in,
        input  phase_result_in,
        input  res_ready,
        output res_valid,
        output res_product,
        output res_count
    );

    modport slave (
        output done_in,
        output phase_result_in,
        output res_ready,
        input  res_valid,
        input  res_product,
        input  res_count
    );
endinterface

// File: rtl/mult_result_stage.sv
// Result stage behind the Booth multiplier pipeline register.
// Turns each rising edge of done_in into one push of phase_result_in[64:1]
// into a DEPTH-entry FIFO, and presents the FIFO head on a valid/ready port.
// Optional feature macro: MULT_SAT_EN adds a saturated 32-bit view of the head
// (res_sat32) and a flag telling whether saturation happened (res_sat_flag).
//
// Handshake: a beat transfers on a rising clk edge where res_valid & res_ready
// are both high; res_valid never drops and res_product never changes while
// res_valid is high and res_ready is low; res_valid == (res_count != 0).
module mult_result_stage #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    mult_result_if.master       bus,
    output logic                overflow,
    input  logic                clr_ovf
`ifdef MULT_SAT_EN
    ,
    output logic [31:0]         res_sat32,
    output logic                res_sat_flag
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic             done_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic [63:0]      mem [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic do_write;
    logic drop;

    // Bit 0 of the accumulator is the Booth q-1 bit and carries no product data.
    logic unused_q1;
    assign unused_q1 = bus.phase_result_in[0];

    assign push     = bus.done_in & ~done_q;
    assign pop      = bus.res_valid & bus.res_ready;
    assign full     = (count == CNT_W'(DEPTH));
    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot wr_ptr points at, so the write can still proceed.
    assign do_write = push & (~full | pop);
    assign drop     = push & full & ~pop;

    // Registered copy of done_in for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= bus.done_in;
        end
    end

    // Product storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.phase_result_in[64:1];
        end
    end

    // Next occupancy: one write and one pop in the same cycle cancel out.
    always_comb begin
        count_n = count;
        if (do_write && !pop) begin
            count_n = count + 1'b1;
        end else if (!do_write && pop) begin
            count_n = count - 1'b1;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
        end
    end

    // Sticky overflow: a dropped completion wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Output view of the FIFO head; product reads zero while empty.
    always_comb begin
        bus.res_valid   = (count != '0);
        bus.res_count   = count;
        bus.res_product = bus.res_valid ? mem[rd_ptr] : 64'd0;
    end

`ifdef MULT_SAT_EN
    logic sat_hi;
    logic sat_lo;

    // The head fits in 32 signed bits only when bits 63..31 are all equal.
    assign sat_hi = ~bus.res_product[63] & (|bus.res_product[62:31]);
    assign sat_lo =  bus.res_product[63] & ~(&bus.res_product[62:31]);

    // Saturated head view; res_product is already zero while empty.
    always_comb begin
        res_sat32    = bus.res_product[31:0];
        res_sat_flag = 1'b0;
        if (sat_hi) begin
            res_sat32    = 32'h7FFF_FFFF;
            res_sat_flag = 1'b1;
        end else if (sat_lo) begin
            res_sat32    = 32'h8000_0000;
            res_sat_flag = 1'b1;
        end
    end
`endif
endmodule
